frame_buff_writer: RTL and testbench
====================================

Name: frame_buff_writer

Overview:
- Camera-side writer for the 8-bit grayscale frame buffer; display-side scaling reads the same buffer.
- Accepts the synchronized camera byte stream (RGB565, two bytes per pixel, high byte first, qualified by HREF and framed by VSYNC).
- Assembles each pixel, converts it to 8-bit luma and issues one BRAM write per pixel at address y*H_ACTIVE + x.
- Runs in the system clock domain; camera signals arrive already synchronized, with byte_valid_in as a 1-cycle strobe.

Parameters:
- H_ACTIVE, 320, pixels per line written to the buffer
- V_ACTIVE, 240, lines per frame written to the buffer
- ADDR_W, 17, frame buffer address width (must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE)

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  synchronous active-low reset
- byte_valid_in  input  1  one-cycle strobe: cam_byte_in holds a new byte
- cam_byte_in  input  8  camera data byte
- href_in  input  1  line active (bytes valid only while high)
- vsync_in  input  1  frame sync (high = vertical blanking, new frame)
- buff_addr_out  output  ADDR_W  frame buffer write address
- buff_data_out  output  8  grayscale pixel
- buff_we_out  output  1  write enable, one cycle per pixel
- frame_done_out  output  1  one-cycle pulse at the end of each captured frame
- overflow_out  output  1  sticky: pixel arrived outside H_ACTIVE x V_ACTIVE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk_in, rst_n_in).
- Reset: all outputs 0, x=y=0, state WAIT_FRAME, byte phase = HI, overflow cleared.
- States:
  - WAIT_FRAME: idle until a vsync_in falling edge, then go to WAIT_LINE with y=0.
  - WAIT_LINE: on an href_in rising edge, go to BYTE_HI with x=0.
  - BYTE_HI: a strobe while href=1 latches cam_byte_in as hi byte and moves to BYTE_LO.
  - BYTE_LO: a strobe while href=1 forms pix = {hi, byte}, computes luma, issues the write and returns to BYTE_HI with x+1.
- Luma, combinational, registered with the write:
  - R8 = {r5, r5[4:2]}, G8 = {g6, g6[5:4]}, B8 = {b5, b5[4:2]}.
  - Y = (2*R8 + 5*G8 + B8) >> 3, using an 11-bit intermediate; result is never > 255.
- Write timing:
  - buff_we_out=1 exactly in the cycle after the BYTE_LO strobe, with buff_addr_out = y*H_ACTIVE + x (pre-increment x) and buff_data_out = Y.
  - Latency from low-byte strobe to write: 1 cycle.
  - Address and data hold their last value when we=0.
- Line end (href falling edge, any state after WAIT_LINE):
  - y+1, x=0, go to WAIT_LINE.
  - A dangling HI byte is discarded and no write is issued.
- Bounds:
  - If x >= H_ACTIVE or y >= V_ACTIVE at the LO strobe, suppress the write and set overflow_out.
  - overflow_out clears only on reset or at the next vsync falling edge.
  - x and y saturate at H_ACTIVE and V_ACTIVE; they never wrap.
- Frame end (vsync_in rising edge from any state other than WAIT_FRAME):
  - frame_done_out pulses 1 cycle, but only if at least one write occurred this frame.
  - State returns to WAIT_FRAME.
- Precedence:
  - vsync rising edge beats an href edge or strobe in the same cycle; that strobe is dropped.
  - href falling edge with a simultaneous strobe: the strobe is ignored, since bytes count only while href=1.
- Strobes while href=0 or in WAIT_FRAME are ignored.
- Reset asserted mid-line: state is abandoned and no write is issued in the reset cycle or the cycle after.

Optional Feature:
- MIRROR_EN defined: write address = y*H_ACTIVE + (H_ACTIVE-1-x). This gives a horizontally mirrored image so the lightboard reads naturally to the presenter. Bounds checks are unchanged.
- MIRROR_EN undefined: address = y*H_ACTIVE + x.

Test Plan:
- Reset, vsync 1->0, href high, byte pairs 0xFF/0xFF then 0x00/0x00 -> writes (addr 0, data 255) then (addr 1, data 0), each 1 cycle after its LO strobe.
- Pixels 0xF800, 0x07E0, 0x001F on line 0 -> data 63, 159, 31 at addr 0, 1, 2.
- Two lines of 320 pixels -> line 1 first write at addr 320; an odd trailing byte before href falls produces no write.
- 321st pixel on a line -> no write, overflow_out=1 and held until the next vsync falling edge; a full 320x240 frame then vsync rising -> frame_done_out is a single 1-cycle pulse.
- rst_n_in low for 1 cycle between HI and LO strobes -> no write; the next frame starts at addr 0.
- MIRROR_EN defined, first pixel of line 2 -> addr 2*320+319 = 959.

Source files
------------

// File: rtl/frame_buff_writer.sv
// frame_buff_writer: RGB565 camera byte stream to 8-bit luma frame buffer writes.
// Define MIRROR_EN for horizontally mirrored write addresses.
module frame_buff_writer #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              byte_valid_in,
  input  logic [7:0]        cam_byte_in,
  input  logic              href_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] buff_addr_out,
  output logic [7:0]        buff_data_out,
  output logic              buff_we_out,
  output logic              frame_done_out,
  output logic              overflow_out
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, BYTE_HI, BYTE_LO} state_t;
  state_t state;
  logic [XW-1:0] x, x_inc;
  logic [YW-1:0] y, y_inc;
  logic [7:0] hi, r8, g8, b8, luma;
  logic [15:0] pix;
  logic [10:0] sum;
  logic [ADDR_W-1:0] col, addr_next;
  logic href_d, vsync_d, wrote, in_bounds;
  logic href_rise, href_fall, vs_rise, vs_fall;
  assign href_rise = href_in & ~href_d;
  assign href_fall = ~href_in & href_d;
  assign vs_rise = vsync_in & ~vsync_d;
  assign vs_fall = ~vsync_in & vsync_d;
  assign pix = {hi, cam_byte_in};
  assign r8 = {pix[15:11], pix[15:13]};
  assign g8 = {pix[10:5], pix[10:9]};
  assign b8 = {pix[4:0], pix[4:2]};
  assign sum = 11'(r8) * 11'd2 + 11'(g8) * 11'd5 + 11'(b8);
  assign luma = sum[10:3];
  assign x_inc = (x == XW'(H_ACTIVE)) ? x : x + XW'(1);
  assign y_inc = (y == YW'(V_ACTIVE)) ? y : y + YW'(1);
  assign in_bounds = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
`ifdef MIRROR_EN
  assign col = ADDR_W'(H_ACTIVE - 1) - ADDR_W'(x);
`else
  assign col = ADDR_W'(x);
`endif
  assign addr_next = ADDR_W'(y) * ADDR_W'(H_ACTIVE) + col;
  always_ff @(posedge clk_in) begin
    href_d <= href_in;
    vsync_d <= vsync_in;
    if (!rst_n_in) begin
      state <= WAIT_FRAME;
      x <= '0;
      y <= '0;
      hi <= '0;
      wrote <= 1'b0;
      buff_we_out <= 1'b0;
      buff_addr_out <= '0;
      buff_data_out <= '0;
      frame_done_out <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      buff_we_out <= 1'b0;
      frame_done_out <= 1'b0;
      if (vs_fall) overflow_out <= 1'b0;
      if (state == WAIT_FRAME) begin
        if (vs_fall) begin
          state <= WAIT_LINE;
          x <= '0;
          y <= '0;
          wrote <= 1'b0;
        end
      end else if (vs_rise) begin
        frame_done_out <= wrote;
        state <= WAIT_FRAME;
      end else if (href_fall && state != WAIT_LINE) begin
        y <= y_inc;
        x <= '0;
        state <= WAIT_LINE;
      end else if (state == WAIT_LINE) begin
        if (href_rise) begin
          state <= BYTE_HI;
          x <= '0;
        end
      end else if (byte_valid_in && href_in) begin
        if (state == BYTE_HI) begin
          hi <= cam_byte_in;
          state <= BYTE_LO;
        end else begin
          state <= BYTE_HI;
          x <= x_inc;
          if (in_bounds) begin
            buff_we_out <= 1'b1;
            buff_addr_out <= addr_next;
            buff_data_out <= luma;
            wrote <= 1'b1;
          end else begin
            overflow_out <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_frame_buff_writer.sv
// tb_frame_buff_writer: directed checks of pixel writes, bounds, framing and reset.
module tb_frame_buff_writer;
  logic clk_in = 1'b0;
  logic rst_n_in, byte_valid_in, href_in, vsync_in;
  logic [7:0] cam_byte_in;
  logic [16:0] buff_addr_out;
  logic [7:0] buff_data_out;
  logic buff_we_out, frame_done_out, overflow_out;
  int checks = 0;
  int passed = 0;
  always #5 clk_in = ~clk_in;
  frame_buff_writer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .byte_valid_in(byte_valid_in),
    .cam_byte_in(cam_byte_in), .href_in(href_in), .vsync_in(vsync_in),
    .buff_addr_out(buff_addr_out), .buff_data_out(buff_data_out),
    .buff_we_out(buff_we_out), .frame_done_out(frame_done_out),
    .overflow_out(overflow_out)
  );
  function automatic int ea(input int y, input int x);
`ifdef MIRROR_EN
    return y * 320 + (319 - x);
`else
    return y * 320 + x;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic send_byte(input logic [7:0] b);
    byte_valid_in = 1'b1;
    cam_byte_in = b;
    @(negedge clk_in);
    byte_valid_in = 1'b0;
  endtask
  task automatic pix(input string tag, input logic [15:0] p, input logic ew, input int a, input int d);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
    chk({tag, "_we"}, 32'(buff_we_out), 32'(ew));
    if (ew) begin
      chk({tag, "_addr"}, 32'(buff_addr_out), a);
      chk({tag, "_data"}, 32'(buff_data_out), d);
    end
  endtask
  task automatic line_on();
    href_in = 1'b1;
    @(negedge clk_in);
  endtask
  task automatic line_off();
    href_in = 1'b0;
    @(negedge clk_in);
  endtask
  task automatic frame_end(input string tag, input logic exp);
    vsync_in = 1'b1;
    @(negedge clk_in);
    chk({tag, "_done"}, 32'(frame_done_out), 32'(exp));
    @(negedge clk_in);
    chk({tag, "_done_off"}, 32'(frame_done_out), 0);
  endtask
  task automatic frame_start();
    vsync_in = 1'b0;
    @(negedge clk_in);
  endtask
  initial begin
    rst_n_in = 1'b0;
    vsync_in = 1'b1;
    href_in = 1'b0;
    byte_valid_in = 1'b0;
    cam_byte_in = 8'h00;
    repeat (3) @(negedge clk_in);
    chk("rst_we", 32'(buff_we_out), 0);
    chk("rst_addr", 32'(buff_addr_out), 0);
    chk("rst_data", 32'(buff_data_out), 0);
    chk("rst_done", 32'(frame_done_out), 0);
    chk("rst_ovf", 32'(overflow_out), 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    frame_start();
    line_on();
    pix("white", 16'hFFFF, 1'b1, ea(0, 0), 255);
    @(negedge clk_in);
    chk("hold_we", 32'(buff_we_out), 0);
    chk("hold_addr", 32'(buff_addr_out), ea(0, 0));
    chk("hold_data", 32'(buff_data_out), 255);
    pix("black", 16'h0000, 1'b1, ea(0, 1), 0);
    line_off();
    frame_end("fa", 1'b1);
    frame_start();
    line_on();
    pix("red", 16'hF800, 1'b1, ea(0, 0), 63);
    pix("green", 16'h07E0, 1'b1, ea(0, 1), 159);
    pix("blue", 16'h001F, 1'b1, ea(0, 2), 31);
    send_byte(8'h12);
    href_in = 1'b0;
    @(negedge clk_in);
    chk("dangle_we", 32'(buff_we_out), 0);
    line_on();
    for (int i = 0; i < 320; i++) begin
      send_byte(8'hFF);
      send_byte(8'hFF);
      if (i == 0 || i == 319) begin
        chk("line1_we", 32'(buff_we_out), 1);
        chk("line1_addr", 32'(buff_addr_out), ea(1, i));
      end
    end
    chk("pre_ovf", 32'(overflow_out), 0);
    pix("x_over", 16'hFFFF, 1'b0, 0, 0);
    chk("x_ovf", 32'(overflow_out), 1);
    line_off();
    line_on();
    pix("line2", 16'hFFFF, 1'b1, ea(2, 0), 255);
    chk("ovf_held", 32'(overflow_out), 1);
    line_off();
    frame_end("fb", 1'b1);
    chk("ovf_after_end", 32'(overflow_out), 1);
    frame_start();
    chk("ovf_cleared", 32'(overflow_out), 0);
    repeat (239) begin
      line_on();
      line_off();
    end
    line_on();
    pix("last_line", 16'hF800, 1'b1, ea(239, 0), 63);
    line_off();
    line_on();
    pix("y_over", 16'hFFFF, 1'b0, 0, 0);
    chk("y_ovf", 32'(overflow_out), 1);
    line_off();
    frame_end("fc", 1'b1);
    frame_start();
    frame_end("empty", 1'b0);
    frame_start();
    line_on();
    send_byte(8'hFF);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    chk("rst_mid_we", 32'(buff_we_out), 0);
    send_byte(8'hFF);
    chk("rst_lo_we", 32'(buff_we_out), 0);
    href_in = 1'b0;
    vsync_in = 1'b1;
    @(negedge clk_in);
    frame_start();
    line_on();
    pix("post_rst", 16'h07E0, 1'b1, ea(0, 0), 159);
    send_byte(8'h00);
    vsync_in = 1'b1;
    byte_valid_in = 1'b1;
    cam_byte_in = 8'h00;
    @(negedge clk_in);
    byte_valid_in = 1'b0;
    chk("vs_beats_strobe_we", 32'(buff_we_out), 0);
    chk("vs_beats_strobe_done", 32'(frame_done_out), 1);
    @(negedge clk_in);
    chk("vs_done_off", 32'(frame_done_out), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
